// File: rtl/eci_dcs_tx_arb.sv
`timescale 1ns/1ps
// eci_dcs_tx_arb
// Round-robin merger of the three outbound DCS channels (rsp_wod, rsp_wd,
// fwd_wod) into one ECI transmit packet stream, with a 2-entry output FIFO
// and free-running per-source accepted-packet counters.
//
// Ports:
//   eci_clk, eci_reset_n          clock, async active-low reset
//   rsp_wod_*  (source 0)         header-only packets, widened to full size
//   rsp_wd_*   (source 1)         full packets, passed through
//   fwd_wod_*  (source 2)         header-only packets, widened to full size
//   tx_pkt_*                      merged stream: pkt, size, vc, src, valid/ready
//   cnt_*_o                       packets accepted per source (wrapping)
module eci_dcs_tx_arb #(
    parameter int ECI_WORD_WIDTH        = 64,
    parameter int ECI_PACKET_SIZE       = 17,
    parameter int ECI_PACKET_SIZE_WIDTH = 5,
    parameter int CNT_WIDTH             = 32
) (
    input  logic                                      eci_clk,
    input  logic                                      eci_reset_n,
    input  logic [ECI_WORD_WIDTH-1:0]                 rsp_wod_hdr_i,
    input  logic [ECI_PACKET_SIZE_WIDTH-1:0]          rsp_wod_pkt_size_i,
    input  logic [3:0]                                rsp_wod_pkt_vc_i,
    input  logic                                      rsp_wod_pkt_valid_i,
    output logic                                      rsp_wod_pkt_ready_o,
    input  logic [ECI_PACKET_SIZE*ECI_WORD_WIDTH-1:0] rsp_wd_pkt_i,
    input  logic [ECI_PACKET_SIZE_WIDTH-1:0]          rsp_wd_pkt_size_i,
    input  logic [3:0]                                rsp_wd_pkt_vc_i,
    input  logic                                      rsp_wd_pkt_valid_i,
    output logic                                      rsp_wd_pkt_ready_o,
    input  logic [ECI_WORD_WIDTH-1:0]                 fwd_wod_hdr_i,
    input  logic [ECI_PACKET_SIZE_WIDTH-1:0]          fwd_wod_pkt_size_i,
    input  logic [3:0]                                fwd_wod_pkt_vc_i,
    input  logic                                      fwd_wod_pkt_valid_i,
    output logic                                      fwd_wod_pkt_ready_o,
    output logic [ECI_PACKET_SIZE*ECI_WORD_WIDTH-1:0] tx_pkt_o,
    output logic [ECI_PACKET_SIZE_WIDTH-1:0]          tx_pkt_size_o,
    output logic [3:0]                                tx_pkt_vc_o,
    output logic [1:0]                                tx_pkt_src_o,
    output logic                                      tx_pkt_valid_o,
    input  logic                                      tx_pkt_ready_i,
    output logic [CNT_WIDTH-1:0]                      cnt_rsp_wod_o,
    output logic [CNT_WIDTH-1:0]                      cnt_rsp_wd_o,
    output logic [CNT_WIDTH-1:0]                      cnt_fwd_wod_o
);

    localparam int PKT_W = ECI_PACKET_SIZE * ECI_WORD_WIDTH;
    localparam int PAD_W = PKT_W - ECI_WORD_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0] vld;
    logic       gnt_vld;
    logic [1:0] gnt_idx;
    logic       push, pop, tail;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       head_q, head_d;

    logic [PKT_W-1:0]                 in_pkt;
    logic [ECI_PACKET_SIZE_WIDTH-1:0] in_size;
    logic [3:0]                       in_vc;

    logic [PKT_W-1:0]                 pkt_q  [2];
    logic [ECI_PACKET_SIZE_WIDTH-1:0] size_q [2];
    logic [3:0]                       vc_q   [2];
    logic [1:0]                       src_q  [2];

    logic [CNT_WIDTH-1:0] cnt_wod_q, cnt_wd_q, cnt_fwd_q;

    assign vld     = {fwd_wod_pkt_valid_i, rsp_wd_pkt_valid_i, rsp_wod_pkt_valid_i};
    assign gnt_vld = |vld;

    // First valid source at or after rr_ptr, wrapping 2 -> 0.
    always_comb begin
        gnt_idx = 2'd0;
        case (rr_ptr_q)
            2'd1:    gnt_idx = vld[1] ? 2'd1 : (vld[2] ? 2'd2 : 2'd0);
            2'd2:    gnt_idx = vld[2] ? 2'd2 : (vld[0] ? 2'd0 : 2'd1);
            default: gnt_idx = vld[0] ? 2'd0 : (vld[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Push is decided from registered occupancy only, so ready never
    // depends on tx_pkt_ready_i.
    assign push = gnt_vld && (count_q < 2'd2);
    assign pop  = (count_q != 2'd0) && tx_pkt_ready_i;
    assign tail = head_q ^ count_q[0];

    // Readies are also forced low while reset is held.
    assign rsp_wod_pkt_ready_o = eci_reset_n && push && (gnt_idx == 2'd0);
    assign rsp_wd_pkt_ready_o  = eci_reset_n && push && (gnt_idx == 2'd1);
    assign fwd_wod_pkt_ready_o = eci_reset_n && push && (gnt_idx == 2'd2);

    always_comb begin
        in_pkt  = {{PAD_W{1'b0}}, rsp_wod_hdr_i};
        in_size = rsp_wod_pkt_size_i;
        in_vc   = rsp_wod_pkt_vc_i;
        case (gnt_idx)
            2'd1: begin
                in_pkt  = rsp_wd_pkt_i;
                in_size = rsp_wd_pkt_size_i;
                in_vc   = rsp_wd_pkt_vc_i;
            end
            2'd2: begin
                in_pkt  = {{PAD_W{1'b0}}, fwd_wod_hdr_i};
                in_size = fwd_wod_pkt_size_i;
                in_vc   = fwd_wod_pkt_vc_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (push) begin
            rr_ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge eci_clk or negedge eci_reset_n) begin
        if (!eci_reset_n) begin
            rr_ptr_q  <= 2'd0;
            count_q   <= 2'd0;
            head_q    <= 1'b0;
            cnt_wod_q <= '0;
            cnt_wd_q  <= '0;
            cnt_fwd_q <= '0;
            for (int i = 0; i < 2; i++) begin
                pkt_q[i]  <= '0;
                size_q[i] <= '0;
                vc_q[i]   <= '0;
                src_q[i]  <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            if (push) begin
                pkt_q[tail]  <= in_pkt;
                size_q[tail] <= in_size;
                vc_q[tail]   <= in_vc;
                src_q[tail]  <= gnt_idx;
                case (gnt_idx)
                    2'd1:    cnt_wd_q  <= cnt_wd_q + CNT_ONE;
                    2'd2:    cnt_fwd_q <= cnt_fwd_q + CNT_ONE;
                    default: cnt_wod_q <= cnt_wod_q + CNT_ONE;
                endcase
            end
        end
    end

    // Outputs are masked while empty so a drained FIFO never shows old data.
    assign tx_pkt_valid_o = (count_q != 2'd0);
    assign tx_pkt_o       = tx_pkt_valid_o ? pkt_q[head_q]  : '0;
    assign tx_pkt_size_o  = tx_pkt_valid_o ? size_q[head_q] : '0;
    assign tx_pkt_vc_o    = tx_pkt_valid_o ? vc_q[head_q]   : '0;
    assign tx_pkt_src_o   = tx_pkt_valid_o ? src_q[head_q]  : '0;

    assign cnt_rsp_wod_o = cnt_wod_q;
    assign cnt_rsp_wd_o  = cnt_wd_q;
    assign cnt_fwd_wod_o = cnt_fwd_q;

endmodule

// File: tb/tb_eci_dcs_tx_arb.sv
`timescale 1ns/1ps
// Bench for eci_dcs_tx_arb: scoreboard on every accepted/emitted packet,
// a vector table for grant/ready/ordering, and directed multi-cycle cases.
// A second instance with 4-bit counters shares the stimulus.
module tb_eci_dcs_tx_arb;

    localparam int WW = 64;
    localparam int PS = 17;
    localparam int SW = 5;
    localparam int PW = WW * PS;

    logic eci_clk = 1'b0;
    logic eci_reset_n = 1'b1;

    logic [WW-1:0] wod_hdr, fwd_hdr;
    logic [PW-1:0] wd_pkt;
    logic [SW-1:0] wod_size, wd_size, fwd_size;
    logic [3:0]    wod_vc, wd_vc, fwd_vc;
    logic          wod_valid, wd_valid, fwd_valid, tx_ready;

    logic          wod_ready, wd_ready, fwd_ready, tx_valid;
    logic [PW-1:0] tx_pkt;
    logic [SW-1:0] tx_size;
    logic [3:0]    tx_vc;
    logic [1:0]    tx_src;
    logic [31:0]   cnt_wod, cnt_wd, cnt_fwd;

    logic          s_wod_ready, s_wd_ready, s_fwd_ready, s_tx_valid;
    logic [PW-1:0] s_tx_pkt;
    logic [SW-1:0] s_tx_size;
    logic [3:0]    s_tx_vc;
    logic [1:0]    s_tx_src;
    logic [3:0]    s_cnt_wod, s_cnt_wd, s_cnt_fwd;

    logic [2:0] rdy;
    assign rdy = {fwd_ready, wd_ready, wod_ready};

    always #5 eci_clk = ~eci_clk;

    eci_dcs_tx_arb dut (
        .eci_clk(eci_clk), .eci_reset_n(eci_reset_n),
        .rsp_wod_hdr_i(wod_hdr), .rsp_wod_pkt_size_i(wod_size), .rsp_wod_pkt_vc_i(wod_vc),
        .rsp_wod_pkt_valid_i(wod_valid), .rsp_wod_pkt_ready_o(wod_ready),
        .rsp_wd_pkt_i(wd_pkt), .rsp_wd_pkt_size_i(wd_size), .rsp_wd_pkt_vc_i(wd_vc),
        .rsp_wd_pkt_valid_i(wd_valid), .rsp_wd_pkt_ready_o(wd_ready),
        .fwd_wod_hdr_i(fwd_hdr), .fwd_wod_pkt_size_i(fwd_size), .fwd_wod_pkt_vc_i(fwd_vc),
        .fwd_wod_pkt_valid_i(fwd_valid), .fwd_wod_pkt_ready_o(fwd_ready),
        .tx_pkt_o(tx_pkt), .tx_pkt_size_o(tx_size), .tx_pkt_vc_o(tx_vc),
        .tx_pkt_src_o(tx_src), .tx_pkt_valid_o(tx_valid), .tx_pkt_ready_i(tx_ready),
        .cnt_rsp_wod_o(cnt_wod), .cnt_rsp_wd_o(cnt_wd), .cnt_fwd_wod_o(cnt_fwd)
    );

    eci_dcs_tx_arb #(.CNT_WIDTH(4)) dut_small (
        .eci_clk(eci_clk), .eci_reset_n(eci_reset_n),
        .rsp_wod_hdr_i(wod_hdr), .rsp_wod_pkt_size_i(wod_size), .rsp_wod_pkt_vc_i(wod_vc),
        .rsp_wod_pkt_valid_i(wod_valid), .rsp_wod_pkt_ready_o(s_wod_ready),
        .rsp_wd_pkt_i(wd_pkt), .rsp_wd_pkt_size_i(wd_size), .rsp_wd_pkt_vc_i(wd_vc),
        .rsp_wd_pkt_valid_i(wd_valid), .rsp_wd_pkt_ready_o(s_wd_ready),
        .fwd_wod_hdr_i(fwd_hdr), .fwd_wod_pkt_size_i(fwd_size), .fwd_wod_pkt_vc_i(fwd_vc),
        .fwd_wod_pkt_valid_i(fwd_valid), .fwd_wod_pkt_ready_o(s_fwd_ready),
        .tx_pkt_o(s_tx_pkt), .tx_pkt_size_o(s_tx_size), .tx_pkt_vc_o(s_tx_vc),
        .tx_pkt_src_o(s_tx_src), .tx_pkt_valid_o(s_tx_valid), .tx_pkt_ready_i(tx_ready),
        .cnt_rsp_wod_o(s_cnt_wod), .cnt_rsp_wd_o(s_cnt_wd), .cnt_fwd_wod_o(s_cnt_fwd)
    );

    typedef struct packed {
        logic [PW-1:0] pkt;
        logic [SW-1:0] size;
        logic [3:0]    vc;
        logic [1:0]    src;
    } ent_t;

    typedef struct {
        logic [2:0] vld;
        logic       txr;
        logic [2:0] rdy;
        logic       txv;
        logic [1:0] src;
    } vec_t;

    ent_t sb[$];
    vec_t tbl[14];
    int   n_chk = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;

    task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic txr);
        wod_valid = v[0];
        wd_valid  = v[1];
        fwd_valid = v[2];
        tx_ready  = txr;
        wod_hdr   = {$urandom, $urandom};
        fwd_hdr   = {$urandom, $urandom};
        for (int w = 0; w < PS; w++) wd_pkt[w*WW +: WW] = {$urandom, $urandom};
        wod_size  = SW'($urandom_range(1, 17));
        wd_size   = SW'($urandom_range(1, 17));
        fwd_size  = SW'($urandom_range(1, 17));
        wod_vc    = 4'($urandom);
        wd_vc     = 4'($urandom);
        fwd_vc    = 4'($urandom);
    endtask

    // One clock: drive at the falling edge, return 1 ns before the rising edge.
    task automatic cyc(input logic [2:0] v, input logic txr);
        @(negedge eci_clk);
        drive(v, txr);
        #4;
    endtask

    task automatic do_reset();
        @(negedge eci_clk);
        drive(3'b000, 1'b0);
        eci_reset_n = 1'b0;
        repeat (2) @(negedge eci_clk);
        sb.delete();
        acc_cnt = 0;
        eci_reset_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            cyc(3'b000, 1'b1);
            n++;
        end
        @(negedge eci_clk);
        chk(name, PW'(sb.size()), PW'(0));
        chk({name, "_valid"}, PW'(tx_valid), PW'(0));
    endtask

    // Scoreboard: capture at accept, compare at pop.
    always @(negedge eci_clk) begin : monitor
        ent_t e;
        #4;
        if (wod_valid && wod_ready) begin
            sb.push_back('{pkt: {{(PW-WW){1'b0}}, wod_hdr}, size: wod_size, vc: wod_vc, src: 2'd0});
            acc_cnt++;
        end
        if (wd_valid && wd_ready) begin
            sb.push_back('{pkt: wd_pkt, size: wd_size, vc: wd_vc, src: 2'd1});
            acc_cnt++;
        end
        if (fwd_valid && fwd_ready) begin
            sb.push_back('{pkt: {{(PW-WW){1'b0}}, fwd_hdr}, size: fwd_size, vc: fwd_vc, src: 2'd2});
            acc_cnt++;
        end
        chk("ready_onehot", PW'($countones(rdy) <= 1), PW'(1));
        if (tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", PW'(1), PW'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_pkt", tx_pkt, e.pkt);
                chk("sb_size", PW'(tx_size), PW'(e.size));
                chk("sb_vc", PW'(tx_vc), PW'(e.vc));
                chk("sb_src", PW'(tx_src), PW'(e.src));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [PW-1:0] held;
        logic [1:0]    exp_s;

        tbl[0]  = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0};
        tbl[1]  = '{3'b111, 1'b1, 3'b001, 1'b0, 2'd0};
        tbl[2]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd0};
        tbl[3]  = '{3'b101, 1'b1, 3'b100, 1'b1, 2'd1};
        tbl[4]  = '{3'b110, 1'b0, 3'b010, 1'b1, 2'd2};
        tbl[5]  = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[6]  = '{3'b111, 1'b1, 3'b000, 1'b1, 2'd2};
        tbl[7]  = '{3'b001, 1'b0, 3'b001, 1'b1, 2'd1};
        tbl[8]  = '{3'b000, 1'b1, 3'b000, 1'b1, 2'd1};
        tbl[9]  = '{3'b000, 1'b1, 3'b000, 1'b1, 2'd0};
        tbl[10] = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0};
        tbl[11] = '{3'b100, 1'b1, 3'b100, 1'b0, 2'd0};
        tbl[12] = '{3'b000, 1'b1, 3'b000, 1'b1, 2'd2};
        tbl[13] = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0};

        // Reset state, with all valids high to exercise ready gating.
        drive(3'b111, 1'b0);
        #1 eci_reset_n = 1'b0;
        #2;
        chk("rst_valid", PW'(tx_valid), PW'(0));
        chk("rst_pkt", tx_pkt, PW'(0));
        chk("rst_size", PW'(tx_size), PW'(0));
        chk("rst_vc", PW'(tx_vc), PW'(0));
        chk("rst_src", PW'(tx_src), PW'(0));
        chk("rst_ready", PW'(rdy), PW'(0));
        chk("rst_cnt", PW'({cnt_wod, cnt_wd, cnt_fwd}), PW'(0));
        do_reset();

        // Single fwd_wod header.
        @(negedge eci_clk);
        drive(3'b100, 1'b0);
        fwd_hdr  = 64'hDEAD_BEEF;
        fwd_size = 5'd1;
        fwd_vc   = 4'd8;
        #4;
        chk("single_ready", PW'(rdy), PW'(3'b100));
        cyc(3'b000, 1'b0);
        chk("single_valid", PW'(tx_valid), PW'(1));
        chk("single_pkt", tx_pkt, {{(PW-WW){1'b0}}, 64'hDEAD_BEEF});
        chk("single_src", PW'(tx_src), PW'(2));
        chk("single_size", PW'(tx_size), PW'(1));
        chk("single_vc", PW'(tx_vc), PW'(8));
        chk("single_cnt_fwd", PW'(cnt_fwd), PW'(1));
        chk("single_cnt_other", PW'({cnt_wod, cnt_wd}), PW'(0));
        drain("single_drain");

        // Vector table: grant order, ready gating, FIFO order.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].vld, tbl[i].txr);
            chk($sformatf("tbl%0d_ready", i), PW'(rdy), PW'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), PW'(tx_valid), PW'(tbl[i].txv));
            if (tbl[i].txv) chk($sformatf("tbl%0d_src", i), PW'(tx_src), PW'(tbl[i].src));
        end
        @(negedge eci_clk);
        chk("tbl_cnt", PW'({cnt_wod, cnt_wd, cnt_fwd}), PW'({32'd2, 32'd2, 32'd2}));
        chk("tbl_small_cnt", PW'(s_cnt_wod), PW'(2));
        drain("tbl_drain");

        // Fairness: all sources valid, sink always ready.
        do_reset();
        exp_s = 2'd0;
        for (int i = 0; i < 300; i++) begin
            cyc(3'b111, 1'b1);
            chk("fair_one_ready", PW'($countones(rdy)), PW'(1));
            if (i > 0) begin
                chk("fair_valid", PW'(tx_valid), PW'(1));
                chk("fair_src", PW'(tx_src), PW'(exp_s));
                exp_s = (exp_s == 2'd2) ? 2'd0 : exp_s + 2'd1;
            end
        end
        cyc(3'b000, 1'b1);
        chk("fair_last_src", PW'(tx_src), PW'(exp_s));
        @(negedge eci_clk);
        chk("fair_cnt", PW'({cnt_wod, cnt_wd, cnt_fwd}), PW'({32'd100, 32'd100, 32'd100}));
        chk("fair_small_cnt", PW'({s_cnt_wod, s_cnt_wd, s_cnt_fwd}), PW'({4'd4, 4'd4, 4'd4}));
        drain("fair_drain");

        // Back-pressure with rsp_wd streaming.
        do_reset();
        held = '0;
        for (int i = 0; i < 5; i++) begin
            cyc(3'b010, 1'b0);
            if (i >= 1) chk("bp_valid", PW'(tx_valid), PW'(1));
            if (i == 1) held = tx_pkt;
            else if (i > 1) chk("bp_hold", tx_pkt, held);
        end
        @(negedge eci_clk);
        chk("bp_accepts", PW'(acc_cnt), PW'(2));
        chk("bp_ready_low", PW'(wd_ready), PW'(0));
        for (int i = 0; i < 4; i++) cyc(3'b010, 1'b1);
        @(negedge eci_clk);
        chk("bp_resume", PW'(acc_cnt), PW'(5));
        drive(3'b000, 1'b1);
        drain("bp_drain");

        // Full buffer with a single-cycle pop: no push that cycle.
        do_reset();
        cyc(3'b001, 1'b0);
        cyc(3'b001, 1'b0);
        cyc(3'b001, 1'b1);
        chk("pp_ready_full", PW'(wod_ready), PW'(0));
        @(negedge eci_clk);
        chk("pp_no_push", PW'(acc_cnt), PW'(2));
        drive(3'b001, 1'b0);
        #4;
        chk("pp_ready_again", PW'(wod_ready), PW'(1));
        chk("pp_valid", PW'(tx_valid), PW'(1));
        @(negedge eci_clk);
        chk("pp_push", PW'(acc_cnt), PW'(3));
        drive(3'b000, 1'b1);
        drain("pp_drain");

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int i = 0; i < 17; i++) cyc(3'b001, 1'b1);
        @(negedge eci_clk);
        drive(3'b000, 1'b1);
        #1;
        chk("wrap_small", PW'(s_cnt_wod), PW'(1));
        chk("wrap_big", PW'(cnt_wod), PW'(17));
        drain("wrap_drain");

        // Asynchronous reset with the buffer full.
        do_reset();
        cyc(3'b010, 1'b0);
        cyc(3'b010, 1'b0);
        @(negedge eci_clk);
        drive(3'b000, 1'b0);
        chk("ar_full", PW'(tx_valid), PW'(1));
        #2 eci_reset_n = 1'b0;
        #1;
        chk("ar_valid_drop", PW'(tx_valid), PW'(0));
        chk("ar_pkt_zero", tx_pkt, PW'(0));
        sb.delete();
        acc_cnt = 0;
        @(negedge eci_clk);
        eci_reset_n = 1'b1;
        cyc(3'b000, 1'b1);
        chk("ar_no_stale", PW'(tx_valid), PW'(0));
        chk("ar_no_stale_pkt", tx_pkt, PW'(0));
        cyc(3'b111, 1'b1);
        chk("ar_rr_restart", PW'(rdy), PW'(3'b001));
        @(negedge eci_clk);
        drive(3'b000, 1'b1);
        drain("ar_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/eci_dcs_tx_arb.md
# eci_dcs_tx_arb

Round-robin merger that sits directly downstream of the DCS clock-domain crossing, in the `eci_clk` domain. It consumes the three outbound DCS channels (`rsp_wod`, `rsp_wd`, `fwd_wod`) and merges them into one packet stream toward the ECI link transmit path. Header-only packets are widened to the full packet format. The block has a 2-entry output buffer, so the output stage sustains full throughput, and it keeps free-running per-source packet counters.

## Interface
Parameters:
- `ECI_WORD_WIDTH`, 64: ECI word width in bits.
- `ECI_PACKET_SIZE`, 17: words per full packet.
- `ECI_PACKET_SIZE_WIDTH`, 5: width of the size field.
- `CNT_WIDTH`, 32: width of each packet counter.

Ports:
- `eci_clk` in 1: the only clock.
- `eci_reset_n` in 1: asynchronous, active-low reset.
- `rsp_wod_hdr_i` in `ECI_WORD_WIDTH`; `rsp_wod_pkt_size_i` in `ECI_PACKET_SIZE_WIDTH`; `rsp_wod_pkt_vc_i` in 4; `rsp_wod_pkt_valid_i` in 1; `rsp_wod_pkt_ready_o` out 1: source 0.
- `rsp_wd_pkt_i` in `ECI_PACKET_SIZE*ECI_WORD_WIDTH`; `rsp_wd_pkt_size_i`, `rsp_wd_pkt_vc_i`, `rsp_wd_pkt_valid_i` in; `rsp_wd_pkt_ready_o` out: source 1.
- `fwd_wod_hdr_i` in `ECI_WORD_WIDTH`; `fwd_wod_pkt_size_i`, `fwd_wod_pkt_vc_i`, `fwd_wod_pkt_valid_i` in; `fwd_wod_pkt_ready_o` out: source 2.
- `tx_pkt_o` out `ECI_PACKET_SIZE*ECI_WORD_WIDTH`: merged packet; word 0 is the header.
- `tx_pkt_size_o` out `ECI_PACKET_SIZE_WIDTH`: packet size in words.
- `tx_pkt_vc_o` out 4: virtual channel.
- `tx_pkt_src_o` out 2: source index (0, 1 or 2).
- `tx_pkt_valid_o` out 1; `tx_pkt_ready_i` in 1: output handshake.
- `cnt_rsp_wod_o`, `cnt_rsp_wd_o`, `cnt_fwd_wod_o` out `CNT_WIDTH` each: packets accepted per source.

## Operation
- **Grant.** Combinational round-robin over the input valids. The search starts at `rr_ptr` (2 bits, values 0..2) and proceeds upward with wrap, so the first valid source at or after `rr_ptr` wins.
- **Ready.**
  - Only the granted source sees `ready_o = (count < 2)`.
  - `count` is the registered occupancy of the buffer.
  - Non-granted sources see `ready_o = 0`.
- **Accept (push).** An accept occurs when the granted source has valid and ready both high.
  - Push `{pkt, size, vc, src}` into the buffer.
  - Update `rr_ptr` to (granted index + 1) mod 3.
  - Increment that source's counter; it wraps modulo 2^`CNT_WIDTH`.
- **Widening.**
  - For header-only sources, the header goes in word 0 and words 1..`ECI_PACKET_SIZE`-1 are driven to zero.
  - `rsp_wd` is passed through unchanged.
  - Size and vc are forwarded verbatim, with no checking.
- **Buffer.** 2-entry FIFO.
  - The outputs show the head entry.
  - `tx_pkt_valid_o = (count != 0)`.
  - Pop on `tx_pkt_valid_o && tx_pkt_ready_i`.
- **Simultaneous push and pop:** `count` is unchanged and order is preserved.
  - Push is gated by the registered count. With count = 2 and a pop in the same cycle, no push occurs.
  - Steady state with `tx_pkt_ready_i` held high keeps count = 1 and 1 packet/cycle.
- **Ordering.** Packets from the same source leave in acceptance order. No packet is dropped or duplicated.
- **Idle.** When no input is valid, `rr_ptr` holds and there is no push.

## Timing
- **Reset values** (`eci_reset_n` low, asynchronous assertion):
  - `count = 0`, `rr_ptr = 0`, all counters 0.
  - `tx_pkt_valid_o = 0`, `tx_pkt_o = 0`, `tx_pkt_size_o = 0`, `tx_pkt_vc_o = 0`, `tx_pkt_src_o = 0`.
  - All `*_ready_o = 0`.
- **Reset release.** Deassertion is used synchronously. Ready may assert in the first cycle after release.
- **Reset mid-operation.** Buffered packets are discarded; there is no partial output.
- **Latency.** A packet accepted at edge N has `tx_pkt_valid_o` high after edge N, i.e. 1 cycle, when the buffer was empty.
- **Back-pressure.**
  - With `tx_pkt_ready_i` low, two packets are accepted, then all readies drop.
  - Output valid and data stay stable until the pop.
- **Ready paths.**
  - `ready_o` depends on the input valids (through the grant) and on registered state only.
  - There is no combinational path from `tx_pkt_ready_i` to any `ready_o`.

## Test plan
- **Single packet.** After reset, a single `fwd_wod` header `0xDEAD_BEEF` with size 1 and vc 8 produces, 1 cycle later:
  - `tx_pkt_o` word 0 = `0xDEAD_BEEF`, all other words 0;
  - `tx_pkt_src_o = 2`, `tx_pkt_size_o = 1`, `tx_pkt_vc_o = 8`;
  - `cnt_fwd_wod_o = 1`.
- **Fairness.** All three sources valid continuously with `tx_pkt_ready_i = 1` gives output src sequence 0, 1, 2, 0, 1, 2, … at 1 packet/cycle. After 300 cycles each counter is 100.
- **Back-pressure.** Hold `tx_pkt_ready_i = 0` with `rsp_wd` streaming.
  - Exactly 2 packets are accepted, then `rsp_wd_pkt_ready_o = 0`.
  - After ready is released, both packets emerge in order with payloads intact, and accepting resumes.
- **Push and pop together.** With count = 2 and `tx_pkt_ready_i = 1` for one cycle, there is a pop and no push. The next cycle shows count = 1 and ready reasserts.
- **Counter wrap.** With `CNT_WIDTH = 4`, sending 17 `rsp_wod` packets leaves `cnt_rsp_wod_o = 1`.
- **Asynchronous reset.** Assert `eci_reset_n` low mid-stream while the buffer is full.
  - Valid drops immediately, without waiting for a clock edge.
  - After release, there is no stale output and `rr_ptr` restarts at source 0.
